// File: rtl/cpu_types_pkg.sv
// Shared CPU-side bus types: the 32-bit word and the RAM bus handshake state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/diaosi_types_pkg.sv
// Project-local constants and encodings for the RAM responder.
package diaosi_types_pkg;

    localparam int RAM_LAT_DEFAULT    = 2;
    localparam int RAM_ADDR_W_DEFAULT = 12;

    // RCOUNT_DIAOSI means a request is latched and its latency is being counted.
    typedef enum logic {
        RIDLE_DIAOSI  = 1'b0,
        RCOUNT_DIAOSI = 1'b1
    } Ram_resp_state_t;

endpackage

// File: rtl/ram_array.sv
// 2**ADDR_W x 32 word RAM: synchronous write, asynchronous read.
// Power-up contents are an index pattern when RAM_INIT_EN is defined, else all zeros.
module ram_array
    import cpu_types_pkg::*;
    import diaosi_types_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  word_t             wdata,
    input  logic [ADDR_W-1:0] raddr,
    output word_t             rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    word_t mem [DEPTH];

`ifdef RAM_INIT_EN
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = word_t'(i);
    end
`else
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end
`endif

    // No reset here: contents survive RST.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ram_responder.sv
// Memory-side end of the RAM bus: BUSY for LAT cycles, then one ACCESS cycle per transaction.
// Memory initial contents are selected by the RAM_INIT_EN macro inside ram_array.
module ram_responder
    import cpu_types_pkg::*;
    import diaosi_types_pkg::*;
#(
    parameter int LAT    = RAM_LAT_DEFAULT,
    parameter int ADDR_W = RAM_ADDR_W_DEFAULT
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      ramREN,
    input  logic      ramWEN,
    input  word_t     ramaddr,
    input  word_t     ramstore,
    output word_t     ramload,
    output ramstate_t ramstate
);

    localparam logic [3:0] LAT_CNT = 4'(LAT);

    Ram_resp_state_t   state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    word_t             req_addr_q, req_addr_d;
    logic              req_wr_q, req_wr_d;

    logic              addr_hi_bad;
    logic              illegal;
    logic              req_any;
    logic              req_match;
    logic              mem_we;
    logic [ADDR_W-1:0] idx;
    word_t             rdata;

    assign idx         = ramaddr[ADDR_W+1:2];
    assign addr_hi_bad = (ramaddr >> (ADDR_W + 2)) != '0;
    assign illegal     = (ramREN && ramWEN) || (ramaddr[1:0] != 2'b00) || addr_hi_bad;
    assign req_any     = ramREN || ramWEN;
    assign req_match   = (state_q == RCOUNT_DIAOSI) && (req_addr_q == ramaddr)
                         && (req_wr_q == ramWEN);

    always_comb begin
        ramstate = BUSY;
        if (RST)                              ramstate = FREE;
        else if (illegal)                     ramstate = ERROR;
        else if (!req_any)                    ramstate = FREE;
        else if (req_match && cnt_q == LAT_CNT) ramstate = ACCESS;
    end

    // A held request that changes address or op restarts the latency from 1.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_addr_d = req_addr_q;
        req_wr_d   = req_wr_q;
        if (ramstate == FREE || ramstate == ERROR) begin
            state_d = RIDLE_DIAOSI;
            cnt_d   = 4'd0;
        end else if (!req_match) begin
            state_d    = RCOUNT_DIAOSI;
            cnt_d      = 4'd1;
            req_addr_d = ramaddr;
            req_wr_d   = ramWEN;
        end else if (ramstate == ACCESS) begin
            state_d = RIDLE_DIAOSI;
            cnt_d   = 4'd0;
        end else begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RIDLE_DIAOSI;
            cnt_q   <= 4'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_addr_q <= req_addr_d;
            req_wr_q   <= req_wr_d;
        end
    end

    // ramstate is forced to FREE under RST, which also blocks the write.
    assign mem_we  = (ramstate == ACCESS) && ramWEN;
    assign ramload = (!RST && ramREN && !illegal) ? rdata : '0;

    ram_array #(
        .ADDR_W(ADDR_W)
    ) u_ram_array (
        .clk   (CLK),
        .we    (mem_we),
        .waddr (idx),
        .wdata (ramstore),
        .raddr (idx),
        .rdata (rdata)
    );

endmodule
